uart_tx_feeder: RTL and testbench

//   Byte FIFO plus launch sequencer directly upstream of the UART transmitter.

---
 rtl/uart_tx_feeder.sv | 130 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Word FIFO feeding a UART transmitter: buffers writes, then launches them one at a time,
// pacing on the transmitter's Active flag and flagging launches it never acknowledges.
module uart_tx_feeder #(
    parameter int WORD          = 8,
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 4
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst_n,
    input  logic                       i_Wr_Valid,
    output logic                       o_Wr_Ready,
    input  logic [WORD-1:0]            i_Wr_Data,
    input  logic                       i_Flush,
    output logic                       o_Tx_DV,
    output logic [WORD-1:0]            o_Tx_Byte,
    input  logic                       i_Tx_Active,
    output logic [$clog2(DEPTH+1)-1:0] o_Count,
    output logic                       o_Empty,
    output logic                       o_Full,
    output logic                       o_Busy,
    output logic                       o_Tx_Err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(START_TIMEOUT);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_START = 2'd1;
    localparam logic [1:0] S_WAIT_END   = 2'd2;

    logic [WORD-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            tx_dv_q, tx_dv_d;
    logic [WORD-1:0] tx_byte_q, tx_byte_d;
    logic            err_q, err_d;
    logic            wr_en, pop;

    assign o_Empty    = (count_q == '0);
    assign o_Full     = (count_q == CW'(DEPTH));
    assign o_Wr_Ready = !o_Full;
    assign o_Count    = count_q;
    assign o_Busy     = (state_q != S_IDLE);
    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Tx_Err   = err_q;

    // A flush discards a same-cycle write; a same-cycle pop still launches its word.
    assign wr_en = i_Wr_Valid && o_Wr_Ready && !i_Flush;
    assign pop   = (state_q == S_IDLE) && !o_Empty && !i_Tx_Active;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_en && !pop)      count_d = count_q + 1'b1;
            else if (pop && !wr_en) count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    tx_byte_d = mem_q[rd_ptr_q];
                    tx_dv_d   = 1'b1;
                    timer_d   = '0;
                    state_d   = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (i_Tx_Active) begin
                    state_d = S_WAIT_END;
                end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_END: begin
                if (!i_Tx_Active) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= i_Wr_Data;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: frame-level transmitter model plus a queue-based reference
// of the feeder, checked every cycle and at directed scenario points.
module tb_uart_tx_feeder;

    localparam int WORD  = 8;
    localparam int DEPTH = 16;
    localparam int TO    = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       tx_active = 1'b0;
    logic       wr_ready, dv, empty, full, busy, err;
    logic [7:0] tx_byte;
    logic [4:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.WORD(WORD), .DEPTH(DEPTH), .START_TIMEOUT(TO)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Wr_Valid(wr_valid), .o_Wr_Ready(wr_ready),
        .i_Wr_Data(wr_data), .i_Flush(flush), .o_Tx_DV(dv), .o_Tx_Byte(tx_byte),
        .i_Tx_Active(tx_active), .o_Count(count), .o_Empty(empty), .o_Full(full),
        .o_Busy(busy), .o_Tx_Err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transmitter: accepts DV only when idle, Active for a whole frame, then one cleanup cycle.
    int         tx_cnt = 0;
    bit         tx_clean = 1'b0;
    bit         tx_dead = 1'b0;
    logic [7:0] frames[$];

    always @(posedge clk) begin
        if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) begin
                tx_active <= 1'b0;
                tx_clean  <= 1'b1;
            end
        end else if (tx_clean) begin
            tx_clean <= 1'b0;
        end else if (dv && !tx_dead) begin
            tx_active <= 1'b1;
            tx_cnt    <= FRAME;
            frames.push_back(tx_byte);
        end
    end

    // Reference: m_ph 0=idle, 1=awaiting Active, 2=frame in flight.
    bit [7:0] m_q[$];
    bit [7:0] m_launched[$];
    int       m_ph = 0;
    int       m_tmr = 0;
    bit       m_dv = 1'b0;
    bit       m_err = 1'b0;
    bit [7:0] m_byte = 8'h00;
    bit       m_pop, m_wr;
    bit       saw_full = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_ph = 0; m_tmr = 0; m_dv = 1'b0; m_err = 1'b0; m_byte = 8'h00;
        end
        check("count", count, m_q.size());
        check("empty", empty, m_q.size() == 0);
        check("full", full, m_q.size() == DEPTH);
        check("wr_ready", wr_ready, m_q.size() != DEPTH);
        check("tx_dv", dv, m_dv);
        check("tx_byte", tx_byte, m_byte);
        check("busy", busy, m_ph != 0);
        check("tx_err", err, m_err);
        check("dv_while_active", dv & tx_active, 0);
        if (full) saw_full = 1'b1;
        if (rst_n) begin
            m_wr  = wr_valid && (m_q.size() < DEPTH) && !flush;
            m_pop = (m_ph == 0) && (m_q.size() > 0) && !tx_active;
            m_dv  = 1'b0;
            if (m_pop) begin
                m_byte = m_q.pop_front();
                m_dv   = 1'b1;
                m_ph   = 1;
                m_tmr  = 0;
                if (!tx_dead) m_launched.push_back(m_byte);
            end else if (m_ph == 1) begin
                if (tx_active) m_ph = 2;
                else if (m_tmr == TO - 1) begin
                    m_err = 1'b1;
                    m_ph  = 0;
                end else m_tmr++;
            end else if (m_ph == 2) begin
                if (!tx_active) m_ph = 0;
            end
            if (flush) m_q.delete();
            else if (m_wr) m_q.push_back(wr_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((m_q.size() != 0 || m_ph != 0 || tx_active || tx_clean || tx_cnt != 0) && n < budget) begin
            step();
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    task automatic wait_active(input string tag, input int budget);
        int n = 0;
        while (!tx_active && n < budget) begin
            step();
            n++;
        end
        check(tag, tx_active, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_ready"}, wr_ready, 1);
        check({tag, "_dv"}, dv, 0);
        check({tag, "_byte"}, tx_byte, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int k;
        bit rdy;

        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Single byte: launch two cycles after the write
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        step();
        wr_valid = 1'b0;
        check("lat_c1_dv", dv, 0);
        step();
        check("lat_c2_dv", dv, 1);
        check("lat_c2_byte", tx_byte, 8'hA5);
        drain("single_drain", 200);

        // Burst until full; extra attempts are held off
        k = 1;
        saw_full = 1'b0;
        for (int i = 0; i < 24; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(k);
            rdy      = wr_ready;
            step();
            if (rdy) k++;
        end
        wr_valid = 1'b0;
        check("burst_full_seen", saw_full, 1);
        drain("burst_drain", 2000);

        // Random traffic with occasional flushes; pointers wrap many times
        for (int i = 0; i < 3000; i++) begin
            wr_valid = ($urandom_range(0, 19) == 0);
            wr_data  = 8'($urandom);
            flush    = ($urandom_range(0, 299) == 0);
            step();
        end
        wr_valid = 1'b0;
        flush    = 1'b0;
        drain("random_drain", 2000);

        // Flush while a frame is in flight
        for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
        wait_active("flush_active", 50);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_frame_alive", tx_active, 1);
        drain("flush_drain", 300);

        // Start timeout: transmitter never answers
        tx_dead = 1'b1;
        wr(8'h3C);
        repeat (8) step();
        check("to_err", err, 1);
        check("to_count", count, 0);
        check("to_busy", busy, 0);
        tx_dead = 1'b0;

        // Reset during data bit 3 of a frame
        wr(8'hC3);
        wait_active("rst_active", 50);
        repeat (CPB + 3 * CPB) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        step();
        rst_n = 1'b1;
        check("post_rst_tx_active", tx_active, 1);
        wr(8'h77);
        drain("rst_drain", 300);

        check("frames_n", frames.size(), m_launched.size());
        for (int i = 0; i < frames.size() && i < m_launched.size(); i++)
            check("frame_byte", frames[i], m_launched[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
